// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the RISC-V instruction-fetch stage.
// Holds the BHT counter encoding and the saturating-counter step.
package rv_fetch_pkg;

  localparam int          XLEN          = 64;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_BRANCH = 7'b110_0011;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } bht_ctr_e;

  localparam bht_ctr_e BHT_CTR_RESET = CTR_WNT;

  // Saturating 2-bit step toward the observed branch outcome
  function automatic bht_ctr_e bht_ctr_next(input bht_ctr_e cur, input logic taken);
    bht_ctr_e nxt;
    nxt = cur;
    case (cur)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = BHT_CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit branch predictors: combinational read, synchronous update.
// A same-index read during an update returns the pre-update counter.
module branch_history_table
  import rv_fetch_pkg::*;
#(
  parameter  int BHT_ENTRIES = 16,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_e         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_ctr_e ctr_r [BHT_ENTRIES];

  assign rd_ctr = ctr_r[rd_idx];

  // Counter storage: all entries start weak-not-taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_r[i] <= BHT_CTR_RESET;
      end
    end else if (upd_en) begin
      ctr_r[upd_idx] <= bht_ctr_next(ctr_r[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection with BHT-based
// branch prediction, and the IF/ID pipeline register.
module fetch_stage
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN        = rv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
  parameter int              BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            bht_update,
  input  logic [XLEN-1:0] bht_update_pc,
  input  logic            bht_taken,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            if_id_pred_taken
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] imm_b_s;
  logic            is_branch_s;
  logic            pred_s;
  bht_ctr_e        rd_ctr_s;
  logic [XLEN-1:0] if_id_pc_r;
  logic [31:0]     if_id_instr_r;
  logic            if_id_valid_r;
  logic            if_id_pred_r;
  logic            unused_s;

  branch_history_table #(
    .BHT_ENTRIES(BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_r[IDX_W+1:2]),
    .rd_ctr    (rd_ctr_s),
    .upd_en    (bht_update),
    .upd_idx   (bht_update_pc[IDX_W+1:2]),
    .upd_taken (bht_taken)
  );

  assign is_branch_s = (imem_rdata[6:0] == OPCODE_BRANCH);
  assign imm_b_s     = {{(XLEN-13){imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                        imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign pred_s      = is_branch_s & rd_ctr_s[1];
  assign unused_s    = ^{imem_rdata[24:12], bht_update_pc[XLEN-1:IDX_W+2], bht_update_pc[1:0]};

  // Next-PC selection: redirect, then stall, then predicted target, then sequential
  always_comb begin
    pc_next_s = pc_r;
    if (flush) begin
      pc_next_s = redirect_pc;
    end else if (!pc_write) begin
      pc_next_s = pc_r;
    end else if (pred_s) begin
      pc_next_s = pc_r + imm_b_s;
    end else begin
      pc_next_s = pc_r + {{(XLEN-3){1'b0}}, 3'd4};
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // IF/ID register: flush inserts a NOP bubble and overrides a stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_pc_r    <= {XLEN{1'b0}};
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
      if_id_pred_r  <= 1'b0;
    end else if (flush) begin
      if_id_pc_r    <= {XLEN{1'b0}};
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
      if_id_pred_r  <= 1'b0;
    end else if (if_id_write) begin
      if_id_pc_r    <= pc_r;
      if_id_instr_r <= imem_rdata;
      if_id_valid_r <= 1'b1;
      if_id_pred_r  <= pred_s;
    end
  end

  assign imem_addr        = pc_r;
  assign if_id_pc         = if_id_pc_r;
  assign if_id_instr      = if_id_instr_r;
  assign if_id_valid      = if_id_valid_r;
  assign if_id_pred_taken = if_id_pred_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle queues the expected
// post-edge state; a monitor pops and compares on the following falling edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, if_id_write, flush, bht_update, bht_taken;
  logic [63:0] redirect_pc, bht_update_pc;
  logic [63:0] imem_addr, if_id_pc;
  logic [31:0] imem_rdata, if_id_instr;
  logic        if_id_valid, if_id_pred_taken;

  logic [63:0] w_imem_addr, w_if_id_pc;
  logic [31:0] w_if_id_instr;
  logic        w_if_id_valid, w_if_id_pred_taken;

  int tests  = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    int          tag;
    string       name;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic        wchk;
    logic [63:0] waddr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Instruction memory: beq x0,x0,16 at 0x10 and 0x30, tagged addi elsewhere
  function automatic logic [31:0] imem(input logic [63:0] a);
    if (a == 64'h10 || a == 64'h30) return 32'h0000_0863;
    return {4'h1, a[7:0], 20'h00013};
  endfunction

  always_comb imem_rdata = imem(imem_addr);

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
    .flush(flush), .redirect_pc(redirect_pc), .bht_update(bht_update),
    .bht_update_pc(bht_update_pc), .bht_taken(bht_taken), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .if_id_pred_taken(if_id_pred_taken)
  );

  fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .pc_write(1'b1), .if_id_write(1'b1),
    .flush(1'b0), .redirect_pc(64'h0), .bht_update(1'b0),
    .bht_update_pc(64'h0), .bht_taken(1'b0), .imem_addr(w_imem_addr),
    .imem_rdata(32'h0000_0013), .if_id_pc(w_if_id_pc), .if_id_instr(w_if_id_instr),
    .if_id_valid(w_if_id_valid), .if_id_pred_taken(w_if_id_pred_taken)
  );

  // Monitor: compare every queued expectation due by this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (imem_addr !== e.addr || if_id_valid !== e.valid || if_id_pc !== e.pc ||
          if_id_instr !== e.instr || if_id_pred_taken !== e.pred) begin
        errors++;
        $display("FAIL %s: got addr=%h valid=%b pc=%h instr=%h pred=%b, want addr=%h valid=%b pc=%h instr=%h pred=%b",
                 e.name, imem_addr, if_id_valid, if_id_pc, if_id_instr, if_id_pred_taken,
                 e.addr, e.valid, e.pc, e.instr, e.pred);
      end
      if (e.wchk) begin
        tests++;
        if (w_imem_addr !== e.waddr) begin
          errors++;
          $display("FAIL %s_wrap: got imem_addr=%h want %h", e.name, w_imem_addr, e.waddr);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge
  task automatic cyc(input string name, input logic pcw, input logic ifw, input logic fl,
                     input logic [63:0] rpc, input logic upd, input logic [63:0] upc,
                     input logic tk, input logic [63:0] e_addr, input logic e_valid,
                     input logic [63:0] e_pc, input logic [31:0] e_instr, input logic e_pred,
                     input logic wchk = 1'b0, input logic [63:0] waddr = 64'h0);
    exp_t e;
    pc_write = pcw; if_id_write = ifw; flush = fl; redirect_pc = rpc;
    bht_update = upd; bht_update_pc = upc; bht_taken = tk;
    e.tag = cyc_cnt + 1; e.name = name; e.addr = e_addr; e.valid = e_valid;
    e.pc = e_pc; e.instr = e_instr; e.pred = e_pred; e.wchk = wchk; e.waddr = waddr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'h0000_0863;
  localparam logic [63:0] WR  = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    reset = 1'b0;
    //   name        pcw   ifw   fl    rpc     upd   upc     tk    addr    v     pc      instr         pred
    cyc("reset0",    1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  NOP,          1'b0, 1'b1, WR);
    cyc("reset1",    1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  NOP,          1'b0, 1'b1, WR);
    reset = 1'b1;
    cyc("seq0",      1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h4,  1'b1, 64'h0,  32'h1000_0013, 1'b0, 1'b1, 64'h0);
    cyc("seq4",      1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h8,  1'b1, 64'h4,  32'h1040_0013, 1'b0);
    cyc("stall0",    1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h8,  1'b1, 64'h4,  32'h1040_0013, 1'b0);
    cyc("stall1",    1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h8,  1'b1, 64'h4,  32'h1040_0013, 1'b0);
    cyc("resume8",   1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'hC,  1'b1, 64'h8,  32'h1080_0013, 1'b0);
    cyc("resumeC",   1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h10, 1'b1, 64'hC,  32'h10C0_0013, 1'b0);
    cyc("flushstall",1'b0, 1'b0, 1'b1, 64'h40, 1'b0, 64'h0,  1'b0, 64'h40, 1'b0, 64'h0,  NOP,          1'b0);
    cyc("after40",   1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h44, 1'b1, 64'h40, 32'h1400_0013, 1'b0);
    cyc("redir10a",  1'b1, 1'b1, 1'b1, 64'h10, 1'b0, 64'h0,  1'b0, 64'h10, 1'b0, 64'h0,  NOP,          1'b0);
    cyc("untrained", 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h14, 1'b1, 64'h10, BEQ,          1'b0);
    cyc("train",     1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h10, 1'b1, 64'h18, 1'b1, 64'h14, 32'h1140_0013, 1'b0);
    cyc("redir10b",  1'b1, 1'b1, 1'b1, 64'h10, 1'b0, 64'h0,  1'b0, 64'h10, 1'b0, 64'h0,  NOP,          1'b0);
    // Same-index update in the predicting cycle: prediction uses counter 10, then it drops to 01
    cyc("pred_pre",  1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h10, 1'b0, 64'h20, 1'b1, 64'h10, BEQ,          1'b1);
    cyc("sat_t1",    1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h10, 1'b1, 64'h24, 1'b1, 64'h20, 32'h1200_0013, 1'b0);
    cyc("sat_t2",    1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h10, 1'b1, 64'h28, 1'b1, 64'h24, 32'h1240_0013, 1'b0);
    cyc("sat_t3",    1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h10, 1'b1, 64'h2C, 1'b1, 64'h28, 32'h1280_0013, 1'b0);
    cyc("sat_t4",    1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h10, 1'b1, 64'h30, 1'b1, 64'h2C, 32'h12C0_0013, 1'b0);
    cyc("sat_nt",    1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h10, 1'b0, 64'h34, 1'b1, 64'h30, BEQ,          1'b0);
    cyc("redir10c",  1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'h30, 1'b0, 64'h10, 1'b0, 64'h0,  NOP,          1'b0);
    cyc("sat_pred",  1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h30, 1'b0, 64'h20, 1'b1, 64'h10, BEQ,          1'b1);
    cyc("redir30a",  1'b1, 1'b1, 1'b1, 64'h30, 1'b1, 64'h30, 1'b0, 64'h30, 1'b0, 64'h0,  NOP,          1'b0);
    cyc("snt_fetch", 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h34, 1'b1, 64'h30, BEQ,          1'b0);
    // One taken update from saturated 00 lands on 01, which must still predict not-taken
    cyc("snt_t1",    1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h30, 1'b1, 64'h38, 1'b1, 64'h34, 32'h1340_0013, 1'b0);
    cyc("redir30b",  1'b1, 1'b1, 1'b1, 64'h30, 1'b0, 64'h0,  1'b0, 64'h30, 1'b0, 64'h0,  NOP,          1'b0);
    cyc("wnt_fetch", 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h34, 1'b1, 64'h30, BEQ,          1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. It sits directly upstream of the decode stage and the hazard-detection/forwarding logic. It owns the PC register, drives the instruction-memory address, and captures the fetched instruction into the IF/ID pipeline register. A 2-bit-counter branch history table (BHT) predicts conditional branches; it honours stall requests (`pc_write`, `if_id_write`) and mispredict flushes from later stages.

## Interface
Parameters:
- `XLEN`, 64: PC and address width.
- `RESET_PC`, 0: PC value after reset.
- `BHT_ENTRIES`, 16: number of BHT counters; power of two, minimum 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_write`  in  1  0 = hold PC (load-use stall from hazard unit).
- `if_id_write`  in  1  0 = hold IF/ID register.
- `flush`  in  1  mispredict/redirect from EX; squashes fetch.
- `redirect_pc`  in  XLEN  correct next PC, valid when `flush`=1.
- `bht_update`  in  1  resolved conditional branch in EX.
- `bht_update_pc`  in  XLEN  PC of the resolved branch.
- `bht_taken`  in  1  actual outcome of the resolved branch.
- `imem_addr`  out  XLEN  current PC to instruction memory (combinational read).
- `imem_rdata`  in  32  instruction at `imem_addr`, same cycle.
- `if_id_pc`  out  XLEN  PC of the instruction in IF/ID.
- `if_id_instr`  out  32  instruction in IF/ID.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pred_taken`  out  1  fetch predicted this instruction as a taken branch.

## Operation
- `imem_addr` = PC register.
- Branch detect: `imem_rdata[6:0]` == 7'b1100011. immB = sign-extend of {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} to XLEN.
- BHT index = PC[log2(BHT_ENTRIES)+1:2]. Prediction `pred` = is_branch AND counter[1].
- Next-PC priority:
  1. `flush`: `redirect_pc`.
  2. `pc_write`=0: hold.
  3. `pred`: PC + immB.
  4. Otherwise: PC + 4.
- PC arithmetic is modulo 2^XLEN; wrap-around is silent.
- IF/ID priority:
  1. `flush`: valid=0, instr=32'h00000013 (NOP), pc=0, pred_taken=0.
  2. `if_id_write`=0: hold all fields.
  3. Otherwise: load PC, `imem_rdata`, valid=1, `pred`.
- `flush` and a stall in the same cycle: flush wins for both PC and IF/ID.
- BHT counters are 2 bits and saturate. Encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- On `bht_update`: if `bht_taken`=1, increment, saturating at 11; if 0, decrement, saturating at 00. The index comes from `bht_update_pc`.
- BHT updates occur regardless of `flush` or stall.
- Update and prediction on the same index in the same cycle: the prediction uses the pre-update value.

## Timing
- Reset (asynchronous, immediate), applied to all outputs and state:
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - IF/ID: valid=0, instr=NOP, pc=0, pred_taken=0.
  - All BHT counters = 01.
- Reset asserted mid-operation discards in-flight state with no partial update. The first fetch occurs on the first rising edge after `reset` rises.
- Fetch-to-IF/ID latency: 1 cycle. The instruction at `imem_addr` in cycle N appears on `if_id_*` in cycle N+1.
- `flush` in cycle N: `imem_addr` = `redirect_pc` in N+1, and IF/ID shows the NOP bubble in N+1.
- Stall: while `pc_write`=`if_id_write`=0, `imem_addr` and `if_id_*` are stable. Resumption has no lost or duplicated instruction.
- BHT update in cycle N affects predictions from cycle N+1.

## Structure
- Shared package `rv_fetch_pkg`: `XLEN`, `NOP_INSTR` (32'h00000013), `OPCODE_BRANCH` (7'b1100011), BHT counter encodings, reset counter value (2'b01).
- One sub-module, `branch_history_table`:
  - Parameterised by `BHT_ENTRIES`.
  - One combinational read port, one synchronous update port, asynchronous active-low reset.
- The PC register, next-PC mux, immB generation and IF/ID register live in `fetch_stage`.

## Test plan
- Reset: hold `reset`=0 with clk running → `imem_addr`=0, `if_id_valid`=0, `if_id_instr`=0x00000013. Release with non-branch instructions → `imem_addr` sequence 0x0, 0x4, 0x8; `if_id_pc` trails by one cycle.
- Stall: `pc_write`=`if_id_write`=0 for 2 cycles while PC=0x8 → `imem_addr` stays 0x8 and IF/ID holds the 0x4 instruction. On release, IF/ID gets 0x8, then 0xC.
- Flush beats stall: `flush`=1, `redirect_pc`=0x40, `pc_write`=0 in the same cycle → next cycle `imem_addr`=0x40, `if_id_valid`=0, `if_id_instr`=NOP.
- Prediction: `beq x0,x0,16` (0x00000863) at 0x10. Apply one `bht_update` taken at 0x10 (01→10), then fetch 0x10 → `if_id_pred_taken`=1 and next `imem_addr`=0x20. Before training, the next address is 0x14.
- Saturation: 4 taken updates then 1 not-taken → counter 10, still predicts taken. Separately, 3 not-taken updates on a fresh entry → 00, and the next fetch is not predicted.
- Wrap: `RESET_PC`=0xFFFF_FFFF_FFFF_FFFC with a non-branch instruction → next `imem_addr`=0x0.
